instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage sitting directly upstream of the 32-entry x 18-bit combinational instruction memory. Owns the program counter, drives the memory address, registers the returned instruction, and splits it into opcode plus four 4-bit fields. Presents the result to the downstream decode/execute stage over a valid/ready handshake. Supports start, redirect (jump/branch) and end-of-program halt.

Parameters:
ADDR_W, 5, program counter / memory address width
INSTR_W, 18, instruction width; fixed format op[17:16], f3[15:12], f2[11:8], f1[7:4], f0[3:0]
RESET_PC, 0, PC value after reset
LAST_ADDR, 31, final program address
WRAP, 0, 1 = PC wraps LAST_ADDR->RESET_PC and keeps running; 0 = halt after LAST_ADDR

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, IDLE->RUN
mem_address  out  ADDR_W  address to instruction memory; equals pc register
mem_instruction  in  INSTR_W  combinational memory data for mem_address, same cycle
redirect_valid  in  1  load PC with redirect_addr, flush output
redirect_addr  in  ADDR_W  redirect target
out_valid  out  1  registered instruction available
out_ready  in  1  downstream accepts this cycle
out_pc  out  ADDR_W  address of presented instruction
out_op  out  2  instr[17:16]
out_f3, out_f2, out_f1, out_f0  out  4 each  instr[15:12], [11:8], [7:4], [3:0]
done  out  1  high in DONE with out_valid low

Behaviour:
- Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, out_valid=0, out_pc=0, out_op=0, out_f3..out_f0=0, done=0. Reset overrides all other inputs, including mid-fetch.
- States: IDLE, RUN, DONE.
- IDLE: no fetch. start -> RUN. pc unchanged.
- fire = (state==RUN) && (!out_valid || out_ready) && !redirect_valid.
- On fire: out_* <= decoded mem_instruction, out_pc <= pc, out_valid <= 1. Then, if pc != LAST_ADDR, pc <= pc+1; if pc == LAST_ADDR: WRAP=1 -> pc <= RESET_PC; WRAP=0 -> pc holds, state -> DONE.
- Latency: instruction at address A appears at out_* one cycle after pc==A with fire. Throughput: 1 instr/cycle while out_ready=1.
- Stall: out_valid && !out_ready -> out_* and pc hold, no fetch. out_* are stable while out_valid=1 and not accepted.
- out_valid && out_ready && !fire -> out_valid <= 0 (drain in DONE/IDLE).
- Redirect (highest priority after rst, any state incl. IDLE/DONE): pc <= redirect_addr, out_valid <= 0 (pending instruction discarded even if out_ready=1), state -> RUN. First fetch from redirect_addr occurs next cycle.
- start while in RUN or DONE: ignored.
- done = (state==DONE) && !out_valid, registered view of state; no arithmetic beyond ADDR_W-bit increment.

Decomposition:
- Shared package: INSTR_W, ADDR_W, field bit positions (OP_MSB/LSB, F3..F0 MSB/LSB), state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One natural sub-module: instr_field_split (combinational slicing of INSTR_W into op/f3/f2/f1/f0), reused by the downstream decoder. PC/FSM and output register stay in instr_fetch_unit.

Test Plan:
- Reset then start, out_ready=1, memory word at 0 = 18'b01_1111_0001_0001_0010 -> cycle after start+1: out_valid=1, out_pc=0, out_op=2'b01, out_f3=4'hF, out_f2=4'h1, out_f1=4'h1, out_f0=4'h2; then out_pc 1,2,3 on consecutive cycles.
- Backpressure: out_ready=0 for 3 cycles while out_pc=4 -> out_pc and fields held, mem_address held at 5; out_ready=1 -> out_pc=5 next cycle, no skipped or duplicated address.
- Redirect: redirect_valid=1, redirect_addr=24 while out_valid=1 at out_pc=10 -> next cycle out_valid=0, mem_address=24; following cycle out_pc=24.
- End of program WRAP=0: run to pc 31 -> out_pc=31 presented, state DONE, no further fetch; after acceptance done=1; redirect_addr=3 -> RUN, out_pc=3.
- End of program WRAP=1: out_pc sequence 30, 31, 0, 1; done stays 0.
- Reset mid-operation: rst=1 during stall at out_pc=7 -> next cycle out_valid=0, all outputs 0, mem_address=0, state IDLE; start required to resume from 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, instruction field positions, FSM encoding and output payload for the fetch stage.
package instr_fetch_unit_pkg;

   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned INSTR_W = 18;
   localparam int unsigned OP_W    = 2;
   localparam int unsigned FIELD_W = 4;

   localparam int unsigned OP_MSB = 17;
   localparam int unsigned OP_LSB = 16;
   localparam int unsigned F3_MSB = 15;
   localparam int unsigned F3_LSB = 12;
   localparam int unsigned F2_MSB = 11;
   localparam int unsigned F2_LSB = 8;
   localparam int unsigned F1_MSB = 7;
   localparam int unsigned F1_LSB = 4;
   localparam int unsigned F0_MSB = 3;
   localparam int unsigned F0_LSB = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_e;

   // Decoded instruction plus the address it came from, as presented downstream.
   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [OP_W-1:0]    op;
      logic [FIELD_W-1:0] f3;
      logic [FIELD_W-1:0] f2;
      logic [FIELD_W-1:0] f1;
      logic [FIELD_W-1:0] f0;
   } fetch_out_t;

endpackage

// File: rtl/instr_fetch_unit_field_split.sv
// Combinational slicing of one instruction word into opcode and four operand fields.
module instr_field_split
   import instr_fetch_unit_pkg::*;
(
   input  logic [INSTR_W-1:0] instruction,
   output logic [OP_W-1:0]    op_c,
   output logic [FIELD_W-1:0] f3_c,
   output logic [FIELD_W-1:0] f2_c,
   output logic [FIELD_W-1:0] f1_c,
   output logic [FIELD_W-1:0] f0_c
);

   assign op_c = instruction[OP_MSB:OP_LSB];
   assign f3_c = instruction[F3_MSB:F3_LSB];
   assign f2_c = instruction[F2_MSB:F2_LSB];
   assign f1_c = instruction[F1_MSB:F1_LSB];
   assign f0_c = instruction[F0_MSB:F0_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the instruction memory, registers and splits the
// returned word, and hands it downstream over valid/ready with start/redirect/halt control.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned LAST_ADDR = 31,
   parameter int unsigned WRAP      = 0
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [ADDR_W-1:0]  mem_address,
   input  logic [INSTR_W-1:0] mem_instruction,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [OP_W-1:0]    out_op,
   output logic [FIELD_W-1:0] out_f3,
   output logic [FIELD_W-1:0] out_f2,
   output logic [FIELD_W-1:0] out_f1,
   output logic [FIELD_W-1:0] out_f0,
   output logic               done
);

   localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(LAST_ADDR);

   fetch_state_e      state;
   fetch_state_e      state_next;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic              out_valid_next;
   logic              done_next;
   fetch_out_t        payload;
   fetch_out_t        payload_next;
   fetch_out_t        decoded_c;
   logic              fire_c;

   logic [OP_W-1:0]    op_c;
   logic [FIELD_W-1:0] f3_c;
   logic [FIELD_W-1:0] f2_c;
   logic [FIELD_W-1:0] f1_c;
   logic [FIELD_W-1:0] f0_c;

   instr_field_split u_split (
      .instruction (mem_instruction),
      .op_c        (op_c),
      .f3_c        (f3_c),
      .f2_c        (f2_c),
      .f1_c        (f1_c),
      .f0_c        (f0_c)
   );

   assign decoded_c = '{pc: pc, op: op_c, f3: f3_c, f2: f2_c, f1: f1_c, f0: f0_c};

   // A fetch happens when running, the output slot is free or being emptied, and no redirect.
   assign fire_c = (state == RUN) && (!out_valid || out_ready) && !redirect_valid;

   assign mem_address = pc;
   assign out_pc      = payload.pc;
   assign out_op      = payload.op;
   assign out_f3      = payload.f3;
   assign out_f2      = payload.f2;
   assign out_f1      = payload.f1;
   assign out_f0      = payload.f0;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, next PC and next output slot; redirect outranks everything but reset.
   always_comb begin
      state_next     = state;
      pc_next        = pc;
      out_valid_next = out_valid;
      payload_next   = payload;

      if (redirect_valid) begin
         pc_next        = redirect_addr;
         out_valid_next = 1'b0;
         state_next     = RUN;
      end else if (fire_c) begin
         payload_next   = decoded_c;
         out_valid_next = 1'b1;
         if (pc == PC_LAST) begin
            if (WRAP != 0) begin
               pc_next = PC_RESET;
            end else begin
               state_next = DONE;
            end
         end else begin
            pc_next = pc + ADDR_W'(1);
         end
      end else begin
         if (out_valid && out_ready) begin
            out_valid_next = 1'b0;
         end
         if ((state == IDLE) && start) begin
            state_next = RUN;
         end
      end

      done_next = (state_next == DONE) && !out_valid_next;
   end

   // PC, output slot and done flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= PC_RESET;
         out_valid <= 1'b0;
         payload   <= '0;
         done      <= 1'b0;
      end else begin
         pc        <= pc_next;
         out_valid <= out_valid_next;
         payload   <= payload_next;
         done      <= done_next;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for the fetch stage: a halting instance (a_*) with a scoreboard on accepted
// instructions, and a wrapping instance (b_*) for the end-of-program wrap sequence.
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [INSTR_W-1:0] mem [32];

   int vectors     = 0;
   int miscompares = 0;
   int unsigned exp_q [$];

   logic               a_rst, a_start, a_rv, a_ready, a_out_valid, a_done;
   logic [ADDR_W-1:0]  a_ra, a_mem_address, a_out_pc;
   logic [INSTR_W-1:0] a_mem_instruction;
   logic [OP_W-1:0]    a_out_op;
   logic [FIELD_W-1:0] a_out_f3, a_out_f2, a_out_f1, a_out_f0;

   logic               b_rst, b_start, b_rv, b_ready, b_out_valid, b_done;
   logic [ADDR_W-1:0]  b_ra, b_mem_address, b_out_pc;
   logic [INSTR_W-1:0] b_mem_instruction;
   logic [OP_W-1:0]    b_out_op;
   logic [FIELD_W-1:0] b_out_f3, b_out_f2, b_out_f1, b_out_f0;

   assign a_mem_instruction = mem[a_mem_address];
   assign b_mem_instruction = mem[b_mem_address];

   instr_fetch_unit #(.RESET_PC(0), .LAST_ADDR(31), .WRAP(0)) u_dut_a (
      .clk (clk), .rst (a_rst), .start (a_start),
      .mem_address (a_mem_address), .mem_instruction (a_mem_instruction),
      .redirect_valid (a_rv), .redirect_addr (a_ra),
      .out_valid (a_out_valid), .out_ready (a_ready), .out_pc (a_out_pc),
      .out_op (a_out_op), .out_f3 (a_out_f3), .out_f2 (a_out_f2),
      .out_f1 (a_out_f1), .out_f0 (a_out_f0), .done (a_done)
   );

   instr_fetch_unit #(.RESET_PC(0), .LAST_ADDR(31), .WRAP(1)) u_dut_b (
      .clk (clk), .rst (b_rst), .start (b_start),
      .mem_address (b_mem_address), .mem_instruction (b_mem_instruction),
      .redirect_valid (b_rv), .redirect_addr (b_ra),
      .out_valid (b_out_valid), .out_ready (b_ready), .out_pc (b_out_pc),
      .out_op (b_out_op), .out_f3 (b_out_f3), .out_f2 (b_out_f2),
      .out_f1 (b_out_f1), .out_f0 (b_out_f0), .done (b_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every instruction accepted by downstream on instance a is popped and checked.
   int unsigned        sb_pc;
   logic [INSTR_W-1:0] sb_word;
   always @(negedge clk) begin
      if (a_out_valid && a_ready && !a_rv && !a_rst) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            sb_pc   = exp_q.pop_front();
            sb_word = mem[sb_pc];
            check("sb_pc", 32'(a_out_pc), sb_pc);
            check("sb_op", 32'(a_out_op), 32'(sb_word[17:16]));
            check("sb_f3", 32'(a_out_f3), 32'(sb_word[15:12]));
            check("sb_f2", 32'(a_out_f2), 32'(sb_word[11:8]));
            check("sb_f1", 32'(a_out_f1), 32'(sb_word[7:4]));
            check("sb_f0", 32'(a_out_f0), 32'(sb_word[3:0]));
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = INSTR_W'($urandom);
      mem[0] = 18'b01_1111_0001_0001_0010;

      a_rst = 1'b1; a_start = 1'b0; a_rv = 1'b0; a_ra = '0; a_ready = 1'b0;
      b_rst = 1'b1; b_start = 1'b0; b_rv = 1'b0; b_ra = '0; b_ready = 1'b1;
      tick(); tick();

      check("rst_valid", 32'(a_out_valid), 32'd0);
      check("rst_pc",    32'(a_out_pc), 32'd0);
      check("rst_op",    32'(a_out_op), 32'd0);
      check("rst_f3",    32'(a_out_f3), 32'd0);
      check("rst_done",  32'(a_done), 32'd0);
      check("rst_addr",  32'(a_mem_address), 32'd0);

      // Start and stream at full throughput.
      a_rst = 1'b0;
      for (int i = 0; i <= 9; i++) exp_q.push_back(i);
      a_ready = 1'b1; a_start = 1'b1;
      tick(); a_start = 1'b0;
      check("start_no_out", 32'(a_out_valid), 32'd0);
      tick();
      check("first_valid", 32'(a_out_valid), 32'd1);
      check("first_pc",    32'(a_out_pc), 32'd0);
      check("first_op",    32'(a_out_op), 32'h1);
      check("first_f3",    32'(a_out_f3), 32'hF);
      check("first_f2",    32'(a_out_f2), 32'h1);
      check("first_f1",    32'(a_out_f1), 32'h1);
      check("first_f0",    32'(a_out_f0), 32'h2);
      check("first_addr",  32'(a_mem_address), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("stream_pc", 32'(a_out_pc), 32'(k));
      end

      // Backpressure at out_pc=4.
      a_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_pc",    32'(a_out_pc), 32'd4);
         check("stall_valid", 32'(a_out_valid), 32'd1);
         check("stall_addr",  32'(a_mem_address), 32'd5);
         check("stall_op",    32'(a_out_op), 32'(mem[4][17:16]));
         check("stall_f0",    32'(a_out_f0), 32'(mem[4][3:0]));
      end
      a_ready = 1'b1;
      for (int k = 5; k <= 10; k++) begin
         tick();
         check("resume_pc", 32'(a_out_pc), 32'(k));
      end

      // Redirect to 24 while out_pc=10 is presented; 10 is discarded.
      a_rv = 1'b1; a_ra = 5'd24;
      tick(); a_rv = 1'b0;
      check("redir_valid", 32'(a_out_valid), 32'd0);
      check("redir_addr",  32'(a_mem_address), 32'd24);
      for (int i = 24; i <= 31; i++) exp_q.push_back(i);
      for (int k = 24; k <= 31; k++) begin
         tick();
         check("redir_pc", 32'(a_out_pc), 32'(k));
      end

      // End of program without wrap.
      check("last_done",  32'(a_done), 32'd0);
      check("last_addr",  32'(a_mem_address), 32'd31);
      a_ready = 1'b0;
      tick();
      check("halt_pc",    32'(a_out_pc), 32'd31);
      check("halt_valid", 32'(a_out_valid), 32'd1);
      check("halt_addr",  32'(a_mem_address), 32'd31);
      check("halt_done",  32'(a_done), 32'd0);
      a_ready = 1'b1;
      tick();
      check("drain_valid", 32'(a_out_valid), 32'd0);
      check("drain_done",  32'(a_done), 32'd1);
      tick();
      check("done_hold",      32'(a_done), 32'd1);
      check("done_no_fetch",  32'(a_out_valid), 32'd0);

      // Redirect out of DONE.
      for (int i = 3; i <= 6; i++) exp_q.push_back(i);
      a_rv = 1'b1; a_ra = 5'd3;
      tick(); a_rv = 1'b0;
      check("exit_done",  32'(a_done), 32'd0);
      check("exit_valid", 32'(a_out_valid), 32'd0);
      check("exit_addr",  32'(a_mem_address), 32'd3);
      for (int k = 3; k <= 7; k++) begin
         tick();
         check("rerun_pc", 32'(a_out_pc), 32'(k));
      end

      // Reset during a stall at out_pc=7.
      a_ready = 1'b0;
      tick();
      check("pre_rst_pc", 32'(a_out_pc), 32'd7);
      a_rst = 1'b1;
      tick(); a_rst = 1'b0;
      check("mrst_valid", 32'(a_out_valid), 32'd0);
      check("mrst_pc",    32'(a_out_pc), 32'd0);
      check("mrst_op",    32'(a_out_op), 32'd0);
      check("mrst_f2",    32'(a_out_f2), 32'd0);
      check("mrst_f0",    32'(a_out_f0), 32'd0);
      check("mrst_done",  32'(a_done), 32'd0);
      check("mrst_addr",  32'(a_mem_address), 32'd0);
      tick();
      check("idle_valid", 32'(a_out_valid), 32'd0);
      check("idle_addr",  32'(a_mem_address), 32'd0);

      exp_q.push_back(0); exp_q.push_back(1);
      a_start = 1'b1; a_ready = 1'b1;
      tick(); a_start = 1'b0;
      for (int k = 0; k <= 2; k++) begin
         tick();
         check("restart_pc", 32'(a_out_pc), 32'(k));
      end
      a_ready = 1'b0;
      tick();
      check("sb_leftover", 32'(exp_q.size()), 32'd0);

      // Wrapping instance: jump near the end and watch 30, 31, 0, 1.
      b_rst = 1'b0; b_start = 1'b1;
      tick(); b_start = 1'b0;
      b_rv = 1'b1; b_ra = 5'd29;
      tick(); b_rv = 1'b0;
      tick();
      check("wrap_29", 32'(b_out_pc), 32'd29);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("wrap_pc",    32'(b_out_pc), (k < 2) ? 32'(30 + k) : 32'(k - 2));
         check("wrap_valid", 32'(b_out_valid), 32'd1);
         check("wrap_done",  32'(b_done), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
